// File: rtl/ascon_io_ctrl.sv
// ascon_io_ctrl: byte-serial operand loader, permutation-core launcher and
// result reader for an Ascon core, with a watchdog on core completion.
module ascon_io_ctrl #(
   parameter int unsigned TIMEOUT = 200
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   wr_data,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [2:0]   mode_in,
   input  logic         start,
   input  logic         abort,
   input  logic         core_done,
   input  logic [319:0] state_in,
   output logic [127:0] reg0_128b,
   output logic [127:0] reg1_128b,
   output logic [127:0] reg2_128b,
   output logic [2:0]   operation_mode,
   output logic         operation_ready,
   output logic [7:0]   rd_data,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic         busy,
   output logic         error
);
   typedef enum logic [1:0] {LOAD, ARMED, RUN, READ} state_t;
   state_t state, state_nxt;
   logic [5:0]   byte_cnt, rd_cnt;
   logic [7:0]   wait_cnt;
   logic [383:0] regs;
   logic [319:0] snap;
   logic [8:0]   wr_idx, rd_idx;
   assign wr_idx    = 9'd383 - {byte_cnt, 3'b000};
   assign rd_idx    = 9'd319 - {rd_cnt, 3'b000};
   assign wr_ready  = state == LOAD;
   assign rd_valid  = state == READ;
   assign busy      = state == RUN;
   assign rd_data   = snap[rd_idx -: 8];
   assign reg0_128b = regs[383:256];
   assign reg1_128b = regs[255:128];
   assign reg2_128b = regs[127:0];
   // abort overrides every other transition
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:  state_nxt = (wr_valid && byte_cnt == 6'd47) ? ARMED : LOAD;
         ARMED: state_nxt = (start && mode_in != 3'd0) ? RUN : ARMED;
         RUN:   state_nxt = core_done ? READ : (wait_cnt == 8'(TIMEOUT - 1)) ? LOAD : RUN;
         READ:  state_nxt = (rd_ready && rd_cnt == 6'd39) ? LOAD : READ;
         default: state_nxt = LOAD;
      endcase
      if (abort) state_nxt = LOAD;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= LOAD;
         byte_cnt        <= '0;
         rd_cnt          <= '0;
         wait_cnt        <= '0;
         regs            <= '0;
         snap            <= '0;
         operation_mode  <= '0;
         operation_ready <= 1'b0;
         error           <= 1'b0;
      end else begin
         state           <= state_nxt;
         operation_ready <= state == ARMED && state_nxt == RUN;
         wait_cnt        <= (state == RUN && state_nxt == RUN) ? wait_cnt + 8'd1 : 8'd0;
         if (abort) byte_cnt <= '0;
         else if (state == LOAD && wr_valid) begin
            regs[wr_idx -: 8] <= wr_data;
            byte_cnt          <= (byte_cnt == 6'd47) ? 6'd0 : byte_cnt + 6'd1;
         end
         if (abort) rd_cnt <= '0;
         else if (state == READ && rd_ready) rd_cnt <= (rd_cnt == 6'd39) ? 6'd0 : rd_cnt + 6'd1;
         if (state == ARMED && state_nxt == RUN) begin
            operation_mode <= mode_in;
            error          <= 1'b0;
         end
         if (state == RUN && state_nxt == READ) snap <= state_in;
         if (state == RUN && state_nxt == LOAD && !abort) error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ascon_io_ctrl.sv
// tb_ascon_io_ctrl: randomized bench for ascon_io_ctrl against a byte-array
// model of the load/run/read protocol.
module tb_ascon_io_ctrl;
   localparam int TMO = 200;
   logic         clk = 0, rst_n = 0;
   logic [7:0]   wr_data = 0;
   logic         wr_valid = 0, wr_ready;
   logic [2:0]   mode_in = 0;
   logic         start = 0, abort = 0, core_done = 0;
   logic [319:0] state_in = 0;
   logic [127:0] reg0_128b, reg1_128b, reg2_128b;
   logic [2:0]   operation_mode;
   logic         operation_ready;
   logic [7:0]   rd_data;
   logic         rd_valid, rd_ready = 0, busy, error;

   ascon_io_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .mode_in(mode_in), .start(start), .abort(abort), .core_done(core_done), .state_in(state_in),
      .reg0_128b(reg0_128b), .reg1_128b(reg1_128b), .reg2_128b(reg2_128b),
      .operation_mode(operation_mode), .operation_ready(operation_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0, pulses = 0, rj = 0;
   logic [7:0]   ld[48];
   logic [7:0]   rb[40];
   logic [383:0] exp_regs;
   logic [7:0]   held;

   always @(negedge clk) if (operation_ready === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [383:0] ld_vec();
      logic [383:0] v = '0;
      for (int i = 0; i < 48; i++) v = {v[375:0], ld[i]};
      return v;
   endfunction

   task automatic load(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         repeat ($urandom_range(0, 2)) step;
         chk("wr_ready_load", wr_ready, 1);
         wr_valid = 1;
         wr_data  = ld[k];
         step;
         wr_valid = 0;
         wr_data  = 8'($urandom);
      end
   endtask

   task automatic load_rand;
      for (int i = 0; i < 48; i++) ld[i] = 8'($urandom);
      load(0, 47);
      exp_regs = ld_vec();
      chk("regs_loaded", {reg0_128b, reg1_128b, reg2_128b}, exp_regs);
      chk("armed_wr_ready", wr_ready, 0);
   endtask

   task automatic start_op(input logic [2:0] m);
      start   = 1;
      mode_in = m;
      step;
      start   = 0;
      mode_in = 3'($urandom);
   endtask

   task automatic set_core_state;
      state_in = {64'h00001000808c0001, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 40; j++) rb[j] = 8'(state_in >> (8 * (39 - j)));
      rj = 0;
   endtask

   task automatic read_n(input int n);
      int got = 0, budget = 0;
      while (got < n && budget < 1000) begin
         rd_ready = 1'($urandom_range(0, 1));
         if (rd_valid && rd_ready) begin
            chk($sformatf("rd_byte%0d", rj), rd_data, rb[rj]);
            rj++;
            got++;
         end
         step;
         budget++;
      end
      rd_ready = 0;
      chk("rd_count", got, n);
   endtask

   initial begin
      int n, p;
      repeat (3) step;
      rst_n = 1;
      step;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_mode", operation_mode, 0);
      chk("rst_op_ready", operation_ready, 0);
      chk("rst_regs", {reg0_128b, reg1_128b, reg2_128b}, 0);

      core_done = 1; step; core_done = 0;
      chk("done_in_load_rd_valid", rd_valid, 0);
      chk("done_in_load_wr_ready", wr_ready, 1);

      // counting-pattern load with an early start ignored
      for (int i = 0; i < 48; i++) ld[i] = 8'(i);
      load(0, 9);
      start_op(3'd3);
      step;
      chk("start_in_load_wr_ready", wr_ready, 1);
      chk("start_in_load_pulses", pulses, 0);
      load(10, 47);
      chk("reg0_count", reg0_128b, 128'h000102030405060708090a0b0c0d0e0f);
      chk("reg2_last", reg2_128b[7:0], 8'h2f);
      chk("regs_count", {reg0_128b, reg1_128b, reg2_128b}, ld_vec());
      chk("armed_wr_ready", wr_ready, 0);

      start_op(3'd0);
      step;
      chk("mode0_pulses", pulses, 0);
      chk("mode0_busy", busy, 0);
      chk("mode0_wr_ready", wr_ready, 0);

      start_op(3'd1);
      chk("run_op_ready", operation_ready, 1);
      chk("run_busy", busy, 1);
      chk("run_mode", operation_mode, 1);
      set_core_state();
      for (int i = 0; i < 11; i++) begin
         mode_in = 3'($urandom);
         step;
         chk("run_op_ready_low", operation_ready, 0);
      end
      core_done = 1; step; core_done = 0;
      chk("pulse_once", pulses, 1);
      chk("mode_held", operation_mode, 1);
      chk("regs_held_run", {reg0_128b, reg1_128b, reg2_128b}, ld_vec());
      chk("read_rd_valid", rd_valid, 1);
      chk("read_busy", busy, 0);
      read_n(40);
      chk("post_read_wr_ready", wr_ready, 1);
      chk("post_read_rd_valid", rd_valid, 0);
      chk("post_read_error", error, 0);

      // watchdog expiry
      load_rand();
      p = pulses;
      start_op(3'($urandom_range(1, 7)));
      n = 0;
      while (busy && n < 400) begin
         n++;
         step;
      end
      chk("timeout_cycles", n, TMO);
      chk("timeout_error", error, 1);
      chk("timeout_wr_ready", wr_ready, 1);
      chk("timeout_regs", {reg0_128b, reg1_128b, reg2_128b}, exp_regs);
      chk("timeout_pulses", pulses, p + 1);
      core_done = 1; step; core_done = 0;
      chk("late_done_ignored", rd_valid, 0);

      // core_done on the final watchdog cycle wins
      load_rand();
      start_op(3'd2);
      chk("error_cleared", error, 0);
      chk("mode2", operation_mode, 2);
      set_core_state();
      repeat (TMO - 1) step;
      chk("edge_still_busy", busy, 1);
      core_done = 1; step; core_done = 0;
      chk("edge_done_rd_valid", rd_valid, 1);
      chk("edge_done_error", error, 0);
      read_n(20);
      held = rd_data;
      repeat (3) step;
      chk("stall_rd_data", rd_data, held);
      chk("stall_rd_valid", rd_valid, 1);
      abort = 1; step; abort = 0;
      chk("abort_rd_valid", rd_valid, 0);
      chk("abort_wr_ready", wr_ready, 1);
      load_rand();

      // abort beats start in ARMED
      p = pulses;
      abort = 1; start = 1; mode_in = 3'd5; step;
      abort = 0; start = 0;
      step;
      chk("abort_start_busy", busy, 0);
      chk("abort_start_pulses", pulses, p);
      chk("abort_start_wr_ready", wr_ready, 1);
      chk("abort_regs_kept", {reg0_128b, reg1_128b, reg2_128b}, exp_regs);
      load_rand();

      // reset mid-RUN
      start_op(3'd4);
      repeat (3) step;
      p = pulses;
      rst_n = 0;
      #1;
      chk("rst_run_busy", busy, 0);
      chk("rst_run_op_ready", operation_ready, 0);
      step;
      rst_n = 1;
      core_done = 1; step; core_done = 0;
      repeat (5) step;
      chk("rst_run_pulses", pulses, p);
      chk("rst_run_rd_valid", rd_valid, 0);
      chk("rst_run_regs", {reg0_128b, reg1_128b, reg2_128b}, 0);
      chk("rst_run_mode", operation_mode, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ascon_io_ctrl.md
ASCON_IO_CTRL -- requirements
Module: ascon_io_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, max cycles RUN waits for core_done (1..255).
REQ-002 SHALL have port clk input 1 clock; all state on rising edge.
REQ-003 SHALL have port rst_n input 1 reset, asynchronous, active-low.
REQ-004 SHALL have port wr_data input 8 load byte.
REQ-005 SHALL have port wr_valid input 1 load byte valid.
REQ-006 SHALL have port wr_ready output 1 load byte accepted when high with wr_valid.
REQ-007 SHALL have port mode_in input 3 operation mode for next start.
REQ-008 SHALL have port start input 1 start request, level-sampled.
REQ-009 SHALL have port abort input 1 synchronous abort.
REQ-010 SHALL have port core_done input 1 permutation core completion pulse.
REQ-011 SHALL have port state_in input 320 core state {S_0,S_1,S_2,S_3,S_4}.
REQ-012 SHALL have ports reg0_128b, reg1_128b, reg2_128b, each output 128, core operand registers.
REQ-013 SHALL have port operation_mode output 3 registered mode to core.
REQ-014 SHALL have port operation_ready output 1 one-cycle core start pulse.
REQ-015 SHALL have port rd_data output 8 result byte.
REQ-016 SHALL have port rd_valid output 1 result byte valid.
REQ-017 SHALL have port rd_ready input 1 result byte consumed.
REQ-018 SHALL have ports busy output 1 (state RUN) and error output 1 (sticky timeout flag).

Function
REQ-019 SHALL implement FSM states LOAD, ARMED, RUN, READ.
REQ-020 LOAD: wr_ready=1; each wr_valid&wr_ready writes byte k (k=0..47, 6-bit counter) to bits [383-8k -: 8] of {reg0,reg1,reg2}, MSB-first.
REQ-021 LOAD: on acceptance of byte 47, SHALL go ARMED next cycle and clear byte counter; wr_ready=0 outside LOAD.
REQ-022 start in LOAD SHALL be ignored; start in ARMED with mode_in==0 SHALL be ignored.
REQ-023 ARMED: start with mode_in!=0 SHALL latch operation_mode=mode_in, clear error, go RUN; operation_ready SHALL be high exactly the first RUN cycle.
REQ-024 RUN: 8-bit wait counter SHALL count cycles from entry; core_done seen SHALL capture state_in into 320-bit snapshot and go READ next cycle.
REQ-025 RUN: if counter reaches TIMEOUT without core_done, SHALL set error=1 and go LOAD; core_done on same cycle as timeout SHALL win (capture, READ, no error).
REQ-026 core_done outside RUN SHALL be ignored.
REQ-027 READ: rd_valid=1, rd_data=snapshot byte j (j=0..39, MSB-first, bits [319-8j -: 8]); rd_valid&rd_ready advances j.
REQ-028 READ: after byte 39 handshake SHALL go LOAD with counters zero; rd_data stable while rd_valid&!rd_ready.
REQ-029 reg0/1/2 and operation_mode SHALL hold value outside LOAD writes/ARMED start; stay stable throughout RUN.
REQ-030 abort in any state SHALL go LOAD next cycle, clear byte/read/wait counters, drop operation_ready; registers and error retained; abort beats start, wr_valid, core_done on same cycle.
REQ-031 Mode change on mode_in after start SHALL not affect operation_mode.

Reset
REQ-032 On rst_n low: state LOAD, all counters 0, reg0/1/2=0, snapshot=0, operation_mode=0, operation_ready=0, rd_valid=0, rd_data=0, busy=0, error=0, wr_ready=1 after deassertion.
REQ-033 Reset assertion mid-RUN or mid-READ SHALL abandon operation with no further operation_ready or rd_valid.

Verification
REQ-034 Load bytes 0x00..0x2F, start mode 1 -> reg0=0x000102..0F, reg2 ends 0x2F; operation_ready single pulse, operation_mode=1.
REQ-035 Core_done 12 cycles after pulse, state_in S_0=0x00001000808c0001 -> first rd_data 0x00, fifth 0x80; 40 bytes then wr_ready=1.
REQ-036 No core_done, TIMEOUT=200 -> error=1 at cycle 200, state LOAD; next accepted start clears error.
REQ-037 start while only 10 bytes loaded, or mode_in=0 in ARMED -> no operation_ready, state unchanged.
REQ-038 abort at READ byte 20 with rd_ready stalled -> rd_valid=0 next cycle, new 48-byte load accepted from k=0.
REQ-039 rd_ready toggling 50% during READ -> each of 40 bytes delivered exactly once in order.
